// File: rtl/wb_stage.sv
// Writeback stage: commits GPR/CSR/TLB side effects of the retiring
// instruction and resolves its exception into a single-cycle flush.
module wb_stage #(
  parameter int TLB_IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ms_to_ws_valid,
  output logic                  ws_allowin,
  input  logic [31:0]           ms_pc,
  input  logic                  ms_rf_we,
  input  logic [4:0]            ms_rf_waddr,
  input  logic [31:0]           ms_rf_wdata,
  input  logic [31:0]           ms_result,
  input  logic                  ms_csr_re,
  input  logic [86:0]           ms_ex_zip,
  input  logic [5+TLB_IDX_W:0]  ms2ws_tlb_zip,
  input  logic [7:0]            ms2ws_tlb_exc,
  input  logic [31:0]           csr_rvalue,
  output logic [13:0]           csr_num,
  output logic                  csr_we,
  output logic [31:0]           csr_wmask,
  output logic [31:0]           csr_wvalue,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  wb_ex,
  output logic [5:0]            wb_ecode,
  output logic [8:0]            wb_esubcode,
  output logic [31:0]           wb_pc,
  output logic [31:0]           wb_vaddr,
  output logic                  wb_badv_we,
  output logic                  ertn_flush,
  output logic                  refetch_flush,
  output logic                  tlbsrch_we,
  output logic                  tlbsrch_hit,
  output logic [TLB_IDX_W-1:0]  tlbsrch_idx,
  output logic                  tlbrd_we,
  output logic                  tlbwr_we,
  output logic                  tlbfill_we,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_we,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
);

  localparam int TZ_W = 6 + TLB_IDX_W;

  logic            ws_valid_q, ws_valid_d;
  logic [31:0]     ws_pc_q, ws_pc_d;
  logic            ws_rf_we_q, ws_rf_we_d;
  logic [4:0]      ws_rf_waddr_q, ws_rf_waddr_d;
  logic [31:0]     ws_rf_wdata_q, ws_rf_wdata_d;
  logic [31:0]     ws_result_q, ws_result_d;
  logic            ws_csr_re_q, ws_csr_re_d;
  logic [86:0]     ws_ex_zip_q, ws_ex_zip_d;
  logic [TZ_W-1:0] ws_tlb_zip_q, ws_tlb_zip_d;
  logic [7:0]      ws_tlb_exc_q, ws_tlb_exc_d;

  logic ws_ready_go;
  logic flush;
  logic has_ex;

  logic        ws_csr_we;
  logic [31:0] ws_csr_wmask;
  logic [31:0] ws_csr_wvalue;
  logic [13:0] ws_csr_num;
  logic ex_ertn, ex_int, ex_adef, ex_sys;
  logic ex_brk, ex_ine, ex_ale, ex_adem;

  logic tz_refetch, tz_srch, tz_rd, tz_wr;
  logic tz_fill, tz_found;
  logic [TLB_IDX_W-1:0] tz_idx;

  logic e_itlbr, e_pif, e_ippi, e_dtlbr;
  logic e_pil, e_pis, e_dppi, e_pme;

  logic [5:0] ecode;
  logic [8:0] esubcode;
  logic       badv_cause;
  logic       fetch_addr;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = ~ws_valid_q | ws_ready_go;

  assign {ws_csr_we, ws_csr_wmask, ws_csr_wvalue,
          ws_csr_num} = ws_ex_zip_q[86:8];
  assign {ex_ertn, ex_int, ex_adef, ex_sys,
          ex_brk, ex_ine, ex_ale, ex_adem} = ws_ex_zip_q[7:0];
  assign {tz_refetch, tz_srch, tz_rd, tz_wr,
          tz_fill, tz_found, tz_idx} = ws_tlb_zip_q;
  assign {e_itlbr, e_pif, e_ippi, e_dtlbr,
          e_pil, e_pis, e_dppi, e_pme} = ws_tlb_exc_q;

  assign has_ex = (|ws_ex_zip_q[6:0]) | (|ws_tlb_exc_q);

  assign wb_ex         = ws_valid_q & has_ex;
  assign ertn_flush    = ws_valid_q & ex_ertn & ~has_ex;
  assign refetch_flush = ws_valid_q & tz_refetch
                       & ~has_ex & ~ex_ertn;
  assign flush = wb_ex | ertn_flush | refetch_flush;

  // Next-state: flush kills the slot; payload tracks accepted MEM data
  always_comb begin
    ws_valid_d    = ws_valid_q;
    ws_pc_d       = ws_pc_q;
    ws_rf_we_d    = ws_rf_we_q;
    ws_rf_waddr_d = ws_rf_waddr_q;
    ws_rf_wdata_d = ws_rf_wdata_q;
    ws_result_d   = ws_result_q;
    ws_csr_re_d   = ws_csr_re_q;
    ws_ex_zip_d   = ws_ex_zip_q;
    ws_tlb_zip_d  = ws_tlb_zip_q;
    ws_tlb_exc_d  = ws_tlb_exc_q;
    if (flush) begin
      ws_valid_d = 1'b0;
    end else if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid;
    end
    if (ms_to_ws_valid & ws_allowin) begin
      ws_pc_d       = ms_pc;
      ws_rf_we_d    = ms_rf_we;
      ws_rf_waddr_d = ms_rf_waddr;
      ws_rf_wdata_d = ms_rf_wdata;
      ws_result_d   = ms_result;
      ws_csr_re_d   = ms_csr_re;
      ws_ex_zip_d   = ms_ex_zip;
      ws_tlb_zip_d  = ms2ws_tlb_zip;
      ws_tlb_exc_d  = ms2ws_tlb_exc;
    end
  end

  // Stage registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid_q    <= 1'b0;
      ws_pc_q       <= '0;
      ws_rf_we_q    <= 1'b0;
      ws_rf_waddr_q <= '0;
      ws_rf_wdata_q <= '0;
      ws_result_q   <= '0;
      ws_csr_re_q   <= 1'b0;
      ws_ex_zip_q   <= '0;
      ws_tlb_zip_q  <= '0;
      ws_tlb_exc_q  <= '0;
    end else begin
      ws_valid_q    <= ws_valid_d;
      ws_pc_q       <= ws_pc_d;
      ws_rf_we_q    <= ws_rf_we_d;
      ws_rf_waddr_q <= ws_rf_waddr_d;
      ws_rf_wdata_q <= ws_rf_wdata_d;
      ws_result_q   <= ws_result_d;
      ws_csr_re_q   <= ws_csr_re_d;
      ws_ex_zip_q   <= ws_ex_zip_d;
      ws_tlb_zip_q  <= ws_tlb_zip_d;
      ws_tlb_exc_q  <= ws_tlb_exc_d;
    end
  end

  // Exception priority encoder: first set cause wins
  always_comb begin
    ecode      = 6'h00;
    esubcode   = 9'h000;
    badv_cause = 1'b0;
    priority case (1'b1)
      ex_int:  ecode = 6'h00;
      ex_adef: begin ecode = 6'h08; badv_cause = 1'b1; end
      e_itlbr: begin ecode = 6'h3f; badv_cause = 1'b1; end
      e_pif:   begin ecode = 6'h03; badv_cause = 1'b1; end
      e_ippi:  begin ecode = 6'h07; badv_cause = 1'b1; end
      ex_ine:  ecode = 6'h0d;
      ex_sys:  ecode = 6'h0b;
      ex_brk:  ecode = 6'h0c;
      ex_ale:  begin ecode = 6'h09; badv_cause = 1'b1; end
      ex_adem: begin
        ecode      = 6'h08;
        esubcode   = 9'h001;
        badv_cause = 1'b1;
      end
      e_dtlbr: begin ecode = 6'h3f; badv_cause = 1'b1; end
      e_pil:   begin ecode = 6'h01; badv_cause = 1'b1; end
      e_pis:   begin ecode = 6'h02; badv_cause = 1'b1; end
      e_dppi:  begin ecode = 6'h07; badv_cause = 1'b1; end
      e_pme:   begin ecode = 6'h04; badv_cause = 1'b1; end
      default: ;
    endcase
  end

  assign fetch_addr  = ex_adef | e_itlbr | e_pif | e_ippi;
  assign wb_ecode    = ecode;
  assign wb_esubcode = esubcode;
  assign wb_pc       = ws_pc_q;
  assign wb_vaddr    = fetch_addr ? ws_pc_q : ws_result_q;
  assign wb_badv_we  = wb_ex & badv_cause;

  assign rf_we    = ws_valid_q & ws_rf_we_q & ~wb_ex;
  assign rf_waddr = ws_rf_waddr_q;
  assign rf_wdata = ws_csr_re_q ? csr_rvalue : ws_rf_wdata_q;

  assign csr_num    = ws_csr_num;
  assign csr_we     = ws_valid_q & ws_csr_we & ~wb_ex;
  assign csr_wmask  = ws_csr_wmask;
  assign csr_wvalue = ws_csr_wvalue;

  assign tlbsrch_we  = ws_valid_q & tz_srch & ~wb_ex;
  assign tlbrd_we    = ws_valid_q & tz_rd & ~wb_ex;
  assign tlbwr_we    = ws_valid_q & tz_wr & ~wb_ex;
  assign tlbfill_we  = ws_valid_q & tz_fill & ~wb_ex;
  assign tlbsrch_hit = tz_found;
  assign tlbsrch_idx = tz_idx;

  assign debug_wb_pc       = ws_pc_q;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, hand sequences for
// flush/reset corners, then random traffic against a cause-table model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic [31:0] ms_result;
  logic        ms_csr_re;
  logic [86:0] ms_ex_zip;
  logic [9:0]  ms2ws_tlb_zip;
  logic [7:0]  ms2ws_tlb_exc;
  logic [31:0] csr_rvalue;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        wb_badv_we;
  logic        ertn_flush;
  logic        refetch_flush;
  logic        tlbsrch_we;
  logic        tlbsrch_hit;
  logic [3:0]  tlbsrch_idx;
  logic        tlbrd_we;
  logic        tlbwr_we;
  logic        tlbfill_we;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.TLB_IDX_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_result(ms_result), .ms_csr_re(ms_csr_re),
    .ms_ex_zip(ms_ex_zip), .ms2ws_tlb_zip(ms2ws_tlb_zip),
    .ms2ws_tlb_exc(ms2ws_tlb_exc), .csr_rvalue(csr_rvalue),
    .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .wb_badv_we(wb_badv_we),
    .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
    .tlbsrch_we(tlbsrch_we), .tlbsrch_hit(tlbsrch_hit),
    .tlbsrch_idx(tlbsrch_idx), .tlbrd_we(tlbrd_we),
    .tlbwr_we(tlbwr_we), .tlbfill_we(tlbfill_we),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] res;
    logic        cre;
    logic [86:0] ex;
    logic [9:0]  tz;
    logic [7:0]  te;
    logic [31:0] rv;
    logic        e_rf_we;
    logic [31:0] e_wd;
    logic        e_ex;
    logic [5:0]  e_ecode;
    logic [8:0]  e_esub;
    logic [31:0] e_vaddr;
    logic        e_badv;
    logic        e_ertn;
    logic        e_ref;
    logic        e_csr_we;
    logic [3:0]  e_tlb;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] res;
    logic        cre;
    logic [86:0] ex;
    logic [9:0]  tz;
    logic [7:0]  te;
  } ms_t;

  // ecode per cause, listed in priority order
  int ectab[15] = '{0, 8, 63, 3, 7, 13, 11, 12, 9, 8, 63, 1, 2, 7, 4};

  vec_t tv[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [86:0] mkex(
    input logic cwe, input logic [31:0] m, input logic [31:0] w,
    input logic [13:0] n, input logic [7:0] lo);
    return {cwe, m, w, n, lo};
  endfunction

  task automatic drive(input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] res, input logic cre,
                       input logic [86:0] ex, input logic [9:0] tz,
                       input logic [7:0] te);
    ms_to_ws_valid = 1'b1;
    ms_pc = pc; ms_rf_we = we; ms_rf_waddr = wa;
    ms_rf_wdata = wd; ms_result = res; ms_csr_re = cre;
    ms_ex_zip = ex; ms2ws_tlb_zip = tz; ms2ws_tlb_exc = te;
  endtask

  task automatic idle;
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rf_we"}, {31'd0, rf_we}, 0);
    chk({tag, ".rf_waddr"}, {27'd0, rf_waddr}, 0);
    chk({tag, ".rf_wdata"}, rf_wdata, 0);
    chk({tag, ".wb_ex"}, {31'd0, wb_ex}, 0);
    chk({tag, ".ecode"}, {26'd0, wb_ecode}, 0);
    chk({tag, ".esub"}, {23'd0, wb_esubcode}, 0);
    chk({tag, ".wb_pc"}, wb_pc, 0);
    chk({tag, ".vaddr"}, wb_vaddr, 0);
    chk({tag, ".flushes"},
        {29'd0, wb_badv_we, ertn_flush, refetch_flush}, 0);
    chk({tag, ".csr"}, {17'd0, csr_we, csr_num}, 0);
    chk({tag, ".csr_wmask"}, csr_wmask, 0);
    chk({tag, ".csr_wvalue"}, csr_wvalue, 0);
    chk({tag, ".tlb"}, {22'd0, tlbsrch_we, tlbsrch_hit, tlbsrch_idx,
        tlbrd_we, tlbwr_we, tlbfill_we}, 0);
    chk({tag, ".dbg_pc"}, debug_wb_pc, 0);
    chk({tag, ".dbg_we"}, {23'd0, debug_wb_rf_we, debug_wb_rf_wnum}, 0);
    chk({tag, ".dbg_wdata"}, debug_wb_rf_wdata, 0);
  endtask

  function automatic logic m_has_ex(input ms_t s);
    return (|s.ex[6:0]) | (|s.te);
  endfunction

  function automatic logic m_flush(input ms_t s);
    return s.v & (m_has_ex(s) | s.ex[7] | s.tz[9]);
  endfunction

  // Behavioural reference: find the first cause in priority order
  task automatic check_model(input ms_t s);
    logic c[15];
    int w;
    logic ex, ertn, refetch, rfwe, badv;
    logic [5:0] ec;
    logic [8:0] es;
    logic [31:0] va;
    c = '{s.ex[6], s.ex[5], s.te[7], s.te[6], s.te[5],
          s.ex[2], s.ex[4], s.ex[3], s.ex[1], s.ex[0],
          s.te[4], s.te[3], s.te[2], s.te[1], s.te[0]};
    w = -1;
    for (int k = 0; k < 15; k++)
      if (w < 0 && c[k]) w = k;
    ex      = s.v && (w >= 0);
    ertn    = s.v && (w < 0) && s.ex[7];
    refetch = s.v && (w < 0) && !s.ex[7] && s.tz[9];
    ec      = (w >= 0) ? 6'(ectab[w]) : 6'd0;
    es      = (w == 9) ? 9'd1 : 9'd0;
    badv    = ex && !(w == 0 || w == 5 || w == 6 || w == 7);
    va      = (s.ex[5] | s.te[7] | s.te[6] | s.te[5]) ? s.pc : s.res;
    rfwe    = s.v && s.rf_we && !ex;
    chk("allowin", {31'd0, ws_allowin}, 1);
    chk("wb_ex", {31'd0, wb_ex}, {31'd0, ex});
    chk("ertn_flush", {31'd0, ertn_flush}, {31'd0, ertn});
    chk("refetch_flush", {31'd0, refetch_flush}, {31'd0, refetch});
    chk("ecode", {26'd0, wb_ecode}, {26'd0, ec});
    chk("esub", {23'd0, wb_esubcode}, {23'd0, es});
    chk("badv_we", {31'd0, wb_badv_we}, {31'd0, badv});
    chk("vaddr", wb_vaddr, va);
    chk("wb_pc", wb_pc, s.pc);
    chk("rf_we", {31'd0, rf_we}, {31'd0, rfwe});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, s.wa});
    chk("rf_wdata", rf_wdata, s.cre ? csr_rvalue : s.wd);
    chk("csr_we", {31'd0, csr_we},
        {31'd0, s.v && s.ex[86] && !ex});
    chk("csr_num", {18'd0, csr_num}, {18'd0, s.ex[21:8]});
    chk("csr_wmask", csr_wmask, s.ex[85:54]);
    chk("csr_wvalue", csr_wvalue, s.ex[53:22]);
    chk("tlb_we", {28'd0, tlbsrch_we, tlbrd_we, tlbwr_we, tlbfill_we},
        {28'd0, s.tz[8:5] & {4{s.v && !ex}}});
    chk("tlb_hit_idx", {27'd0, tlbsrch_hit, tlbsrch_idx},
        {27'd0, s.tz[4:0]});
    chk("dbg", {debug_wb_pc[22:0], debug_wb_rf_we, debug_wb_rf_wnum},
        {s.pc[22:0], {4{rfwe}}, s.wa});
  endtask

  initial begin
    ms_t s, ns;
    logic [95:0] r96;
    logic [7:0]  lo;
    logic [9:0]  tz;
    resetn = 1'b0;
    csr_rvalue = 32'h0;
    drive(32'h0, 0, 0, 0, 0, 0, '0, '0, '0);
    idle();

    tv[0]  = '{32'h1c000000, 1'b1, 5'd5, 32'h1234, 32'h1234, 1'b0,
               mkex(0, 0, 0, 0, 8'h00), 10'h0, 8'h00, 32'h0,
               1'b1, 32'h1234, 1'b0, 6'h00, 9'h0, 32'h1234,
               1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[1]  = '{32'h1c000004, 1'b1, 5'd4, 32'hdead, 32'h0, 1'b1,
               mkex(0, 0, 0, 0, 8'h00), 10'h0, 8'h00, 32'hb0,
               1'b1, 32'hb0, 1'b0, 6'h00, 9'h0, 32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[2]  = '{32'h1c000008, 1'b1, 5'd6, 32'h0, 32'h0, 1'b1,
               mkex(1, 32'hffffffff, 32'h4, 14'h0, 8'h00),
               10'h0, 8'h00, 32'h77,
               1'b1, 32'h77, 1'b0, 6'h00, 9'h0, 32'h0,
               1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
    tv[3]  = '{32'h1c000010, 1'b1, 5'd7, 32'h55, 32'h80000003, 1'b0,
               mkex(0, 0, 0, 0, 8'h02), 10'h0, 8'h00, 32'h0,
               1'b0, 32'h55, 1'b1, 6'h09, 9'h0, 32'h80000003,
               1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[4]  = '{32'h1c000014, 1'b1, 5'd8, 32'h66, 32'h100, 1'b0,
               mkex(0, 0, 0, 0, 8'h50), 10'h0, 8'h00, 32'h0,
               1'b0, 32'h66, 1'b1, 6'h00, 9'h0, 32'h100,
               1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[5]  = '{32'h1c000020, 1'b0, 5'd0, 32'h0, 32'h200, 1'b0,
               mkex(0, 0, 0, 0, 8'h24), 10'h0, 8'h00, 32'h0,
               1'b0, 32'h0, 1'b1, 6'h08, 9'h0, 32'h1c000020,
               1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[6]  = '{32'h1c000024, 1'b0, 5'd0, 32'h0, 32'h300, 1'b0,
               mkex(0, 0, 0, 0, 8'h01), 10'h0, 8'h00, 32'h0,
               1'b0, 32'h0, 1'b1, 6'h08, 9'h1, 32'h300,
               1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[7]  = '{32'h1c000028, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0,
               mkex(0, 0, 0, 0, 8'h80), 10'h0, 8'h00, 32'h0,
               1'b0, 32'h0, 1'b0, 6'h00, 9'h0, 32'h0,
               1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
    tv[8]  = '{32'h1c00002c, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0,
               mkex(0, 0, 0, 0, 8'h00), 10'h11a, 8'h00, 32'h0,
               1'b0, 32'h0, 1'b0, 6'h00, 9'h0, 32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
    tv[9]  = '{32'h1c000030, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0,
               mkex(0, 0, 0, 0, 8'h00), 10'h240, 8'h00, 32'h0,
               1'b0, 32'h0, 1'b0, 6'h00, 9'h0, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b0, 4'b0010};
    tv[10] = '{32'h1c000034, 1'b1, 5'd9, 32'h11, 32'h400, 1'b0,
               mkex(0, 0, 0, 0, 8'h00), 10'h0, 8'h11, 32'h0,
               1'b0, 32'h11, 1'b1, 6'h3f, 9'h0, 32'h400,
               1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[11] = '{32'h1c000038, 1'b0, 5'd0, 32'h0, 32'h500, 1'b0,
               mkex(0, 0, 0, 0, 8'h00), 10'h0, 8'h80, 32'h0,
               1'b0, 32'h0, 1'b1, 6'h3f, 9'h0, 32'h1c000038,
               1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[12] = '{32'h1c00003c, 1'b0, 5'd0, 32'h0, 32'h600, 1'b0,
               mkex(0, 0, 0, 0, 8'h82), 10'h0, 8'h00, 32'h0,
               1'b0, 32'h0, 1'b1, 6'h09, 9'h0, 32'h600,
               1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[13] = '{32'h1c000040, 1'b1, 5'd3, 32'h99, 32'h700, 1'b0,
               mkex(1, 32'hf, 32'h1, 14'h5, 8'h10), 10'h240, 8'h00,
               32'h0,
               1'b0, 32'h99, 1'b1, 6'h0b, 9'h0, 32'h700,
               1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[14] = '{32'h1c000044, 1'b0, 5'd0, 32'h0, 32'h800, 1'b0,
               mkex(0, 0, 0, 0, 8'h00), 10'h0, 8'h50, 32'h0,
               1'b0, 32'h0, 1'b1, 6'h03, 9'h0, 32'h1c000044,
               1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[15] = '{32'h1c000048, 1'b0, 5'd0, 32'h0, 32'h900, 1'b0,
               mkex(0, 0, 0, 0, 8'h0a), 10'h0, 8'h00, 32'h0,
               1'b0, 32'h0, 1'b1, 6'h0c, 9'h0, 32'h900,
               1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[16] = '{32'h1c00004c, 1'b0, 5'd0, 32'h0, 32'ha00, 1'b0,
               mkex(0, 0, 0, 0, 8'h00), 10'h0, 8'h08, 32'h0,
               1'b0, 32'h0, 1'b1, 6'h01, 9'h0, 32'ha00,
               1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};

    step(); step();
    chk_all_zero("reset");
    resetn = 1'b1;
    step();
    chk_all_zero("post_reset");

    foreach (tv[i]) begin
      drive(tv[i].pc, tv[i].rf_we, tv[i].wa, tv[i].wd, tv[i].res,
            tv[i].cre, tv[i].ex, tv[i].tz, tv[i].te);
      csr_rvalue = tv[i].rv;
      step();
      idle();
      chk($sformatf("v%0d.rf_we", i), {31'd0, rf_we},
          {31'd0, tv[i].e_rf_we});
      chk($sformatf("v%0d.rf_wdata", i), rf_wdata, tv[i].e_wd);
      chk($sformatf("v%0d.rf_waddr", i), {27'd0, rf_waddr},
          {27'd0, tv[i].wa});
      chk($sformatf("v%0d.wb_ex", i), {31'd0, wb_ex},
          {31'd0, tv[i].e_ex});
      chk($sformatf("v%0d.ecode", i), {26'd0, wb_ecode},
          {26'd0, tv[i].e_ecode});
      chk($sformatf("v%0d.esub", i), {23'd0, wb_esubcode},
          {23'd0, tv[i].e_esub});
      chk($sformatf("v%0d.vaddr", i), wb_vaddr, tv[i].e_vaddr);
      chk($sformatf("v%0d.badv_we", i), {31'd0, wb_badv_we},
          {31'd0, tv[i].e_badv});
      chk($sformatf("v%0d.ertn", i), {31'd0, ertn_flush},
          {31'd0, tv[i].e_ertn});
      chk($sformatf("v%0d.refetch", i), {31'd0, refetch_flush},
          {31'd0, tv[i].e_ref});
      chk($sformatf("v%0d.csr_we", i), {31'd0, csr_we},
          {31'd0, tv[i].e_csr_we});
      chk($sformatf("v%0d.tlb", i),
          {28'd0, tlbsrch_we, tlbrd_we, tlbwr_we, tlbfill_we},
          {28'd0, tv[i].e_tlb});
      chk($sformatf("v%0d.hit_idx", i),
          {27'd0, tlbsrch_hit, tlbsrch_idx}, {27'd0, tv[i].tz[4:0]});
      chk($sformatf("v%0d.wb_pc", i), wb_pc, tv[i].pc);
      chk($sformatf("v%0d.dbg_we", i), {28'd0, debug_wb_rf_we},
          {28'd0, {4{tv[i].e_rf_we}}});
      step();
      chk($sformatf("v%0d.after", i),
          {28'd0, rf_we, wb_ex, ertn_flush, refetch_flush}, 0);
    end

    // ertn flush drops the instruction arriving behind it
    drive(32'h1c001000, 0, 0, 0, 0, 0, mkex(0, 0, 0, 0, 8'h80),
          '0, '0);
    step();
    drive(32'h1c001004, 1, 7, 32'h7777, 0, 0, '0, '0, '0);
    chk("ertn.pulse", {31'd0, ertn_flush}, 1);
    chk("ertn.wb_ex", {31'd0, wb_ex}, 0);
    step();
    idle();
    chk("ertn.dropped", {31'd0, rf_we}, 0);
    chk("ertn.one_cycle", {31'd0, ertn_flush}, 0);
    step();

    // exception flush drops the follower as well
    drive(32'h1c002000, 1, 8, 32'h1, 32'h3, 0,
          mkex(0, 0, 0, 0, 8'h02), '0, '0);
    step();
    drive(32'h1c002004, 1, 9, 32'h9999, 0, 0, '0, '0, '0);
    chk("ale.wb_ex", {31'd0, wb_ex}, 1);
    chk("ale.rf_we", {31'd0, rf_we}, 0);
    step();
    idle();
    chk("ale.dropped", {31'd0, rf_we}, 0);
    chk("ale.one_cycle", {31'd0, wb_ex}, 0);
    step();

    // back-to-back commits
    drive(32'h1c003000, 1, 10, 32'haaaa, 0, 0, '0, '0, '0);
    step();
    drive(32'h1c003004, 1, 11, 32'hbbbb, 0, 0, '0, '0, '0);
    chk("b2b.first", {26'd0, rf_we, rf_waddr}, {26'd0, 1'b1, 5'd10});
    step();
    idle();
    chk("b2b.second", {26'd0, rf_we, rf_waddr}, {26'd0, 1'b1, 5'd11});
    chk("b2b.wdata", rf_wdata, 32'hbbbb);
    step();
    chk("b2b.drain", {31'd0, rf_we}, 0);

    // reset mid-sequence
    drive(32'h1c004000, 1, 12, 32'hcccc, 32'h44, 0,
          mkex(1, 32'h1, 32'h2, 14'h3, 8'h00), 10'h11a, '0);
    step();
    chk("rst.commit", {31'd0, rf_we}, 1);
    resetn = 1'b0;
    csr_rvalue = 32'h0;
    drive(32'h1c004004, 1, 13, 32'hdddd, 32'h55, 0, '0, '0, '0);
    step();
    chk_all_zero("rst_mid");
    resetn = 1'b1;
    idle();
    step();
    chk("rst.no_commit", {31'd0, rf_we}, 0);

    // random traffic against the reference model
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    s = '0;
    for (int n = 0; n < 3000; n++) begin
      check_model(s);
      resetn = ($urandom_range(0, 60) != 0);
      r96 = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 5))
        0: lo = 8'($urandom);
        1: lo = 8'h80;
        default: lo = 8'h00;
      endcase
      tz = 10'($urandom);
      tz[9] = ($urandom_range(0, 5) == 0);
      ms_to_ws_valid = ($urandom_range(0, 9) < 7);
      ms_pc = $urandom; ms_rf_we = 1'($urandom);
      ms_rf_waddr = 5'($urandom); ms_rf_wdata = $urandom;
      ms_result = $urandom; ms_csr_re = ($urandom_range(0, 3) == 0);
      ms_ex_zip = {r96[86:8], lo};
      ms2ws_tlb_zip = tz;
      ms2ws_tlb_exc = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h0;
      csr_rvalue = $urandom;
      ns = s;
      if (!resetn) begin
        ns = '0;
      end else begin
        ns.v = m_flush(s) ? 1'b0 : ms_to_ws_valid;
        if (ms_to_ws_valid) begin
          ns.pc = ms_pc; ns.rf_we = ms_rf_we; ns.wa = ms_rf_waddr;
          ns.wd = ms_rf_wdata; ns.res = ms_result;
          ns.cre = ms_csr_re; ns.ex = ms_ex_zip;
          ns.tz = ms2ws_tlb_zip; ns.te = ms2ws_tlb_exc;
        end
      end
      step();
      s = ns;
    end
    check_model(s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
